auction_round_ctrl: RTL and testbench
=====================================

Name: auction_round_ctrl

Overview:
Sequences one bidding round at a time for ten requesters and shares one 10-way registered argmax unit between them. Each round runs in four steps: open the round, collect up to one bid per enabled requester through a valid/ready handshake, evaluate the argmax, then present the grant to downstream and hold it until accepted. The block sits between the requester interfaces and the grant consumer.

Parameters:
bW, 16, bid width in bits
TIMEOUT, 16, maximum number of COLLECT cycles per round (must be 2 or more)
CW, 16, width of the round counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
cfg_en  in  10  requester enable mask, sampled on round open
bid_valid  in  10  per-requester bid offer
bid_value  in  10 x bW  per-requester bid value
bid_ready  out  10  per-requester bid accept
grant_valid  out  1  winner is presented
grant_idx  out  4  winning requester index, 0 to 9
grant_bid  out  bW  winning bid value
grant_ready  in  1  downstream accepts the grant
no_winner  out  1  one-cycle pulse: round closed with no nonzero bid
busy  out  1  state is not IDLE
round_cnt  out  CW  count of completed grants, wraps modulo 2^CW

Behaviour:
- Reset: clk and rst_n (synchronous, active-low). State goes to IDLE; all bid registers and the submitted mask clear.
- Output reset values: bid_ready=0, grant_valid=0, grant_idx=0, grant_bid=0, no_winner=0, busy=0, round_cnt=0.
- Reset mid-round aborts the round with no grant and no pulse.
- States: IDLE, COLLECT, EVAL, GRANT.
- IDLE:
  - bid_ready=0.
  - If |(bid_valid & cfg_en) is true: latch cfg_en into en_q, clear the submitted mask and timer, go to COLLECT.
- COLLECT:
  - bid_ready[i] = en_q[i] & ~submitted[i].
  - Handshake on requester i (valid & ready): latch bid_value[i] into bid_q[i] and set submitted[i].
  - At most one bid per requester per round. Requesters not in en_q never receive ready.
  - Timer increments every COLLECT cycle.
  - Exit to EVAL when (submitted | handshakes this cycle) == en_q, or when timer == TIMEOUT-1.
  - Bids accepted in the closing cycle are counted.
- EVAL: exactly one cycle.
  - Argmax inputs are bid_q[i] where submitted[i]; otherwise 0.
  - Bid value 0 means "no bid".
  - If every argmax input is 0: pulse no_winner for one cycle, clear bid_q and the submitted mask, go to IDLE.
  - Otherwise go to GRANT.
- GRANT:
  - grant_valid=1; grant_idx = registered argmax output; grant_bid = bid_q[grant_idx].
  - Outputs stay stable until grant_ready.
  - On grant_valid & grant_ready: round_cnt+1 (wrapping), clear bid_q and the submitted mask, go to IDLE.
  - A new round can open no earlier than the cycle after IDLE is entered.
- Latency: the first bid handshake to grant_valid is at least 2 cycles (close, then EVAL).
- Boundary conditions:
  - Timeout with a partial set of bids: evaluate only the submitted bids.
  - Single enabled requester: round closes on its handshake.
  - cfg_en changes mid-round: ignored until the next round open.
  - bid_valid deasserted while ready is high: no capture.
  - grant_ready held high: grant lasts exactly one cycle.
- Ties: winner index is whatever the argmax unit resolves. The bench checks only that grant_bid equals the maximum bid and that bid_q[grant_idx] matches it.

Decomposition:
- Package auction_pkg holds:
  - NUM_BIDDERS=10, IDX_W=4;
  - the state enum (IDLE, COLLECT, EVAL, GRANT);
  - typedef bid_t = logic [bW-1:0] with the default width.
- Sub-module: fast_argmax10, the existing 10-way argmax with a registered winner output. It is clocked and reset from clk/rst_n, inputs come from the masked bid_q array, and it has one-cycle latency, consumed by EVAL.
- Controller FSM, timer, mask and bid registers live in auction_round_ctrl itself.

Test Plan:
- Full round: cfg_en=0x3FF; all ten bid in one cycle with value 10*i+5, except requester 6 bidding 200 -> close after 1 COLLECT cycle, EVAL, grant_valid with idx=6, bid=200, round_cnt 0->1 on grant_ready.
- Timeout: cfg_en=0x3FF, TIMEOUT=16; only requesters 2 (bid 40) and 9 (bid 41) bid -> close at timer 15, grant idx=9, bid=41; bid_ready never reasserts for 2 or 9 after their handshakes.
- No winner: requester 3 enabled and bids 0 -> no_winner pulses exactly one cycle, grant_valid stays 0, round_cnt unchanged, busy returns to 0.
- Backpressure: grant_ready held low for 20 cycles -> grant_valid, grant_idx and grant_bid stay stable; bid_ready=0 throughout; one round_cnt increment on release.
- Masking: cfg_en=0x00F, requester 8 bid_valid with 0xFFFF -> bid_ready[8] stays 0; winner is among 0 to 3; a cfg_en change mid-round has no effect.
- Reset mid-GRANT: rst_n=0 for one cycle -> all outputs at reset values next cycle, round_cnt=0, state IDLE; a following round completes normally.

Source files
------------

// File: rtl/auction_pkg.sv
// Shared types and sizing for the auction round controller and its argmax unit.
package auction_pkg;

    localparam int unsigned NUM_BIDDERS   = 10;
    localparam int unsigned IDX_W         = 4;
    localparam int unsigned BID_W_DEFAULT = 16;

    typedef logic [BID_W_DEFAULT-1:0] bid_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EVAL,
        GRANT
    } state_t;

endpackage

// File: rtl/fast_argmax10.sv
// 10-way argmax with a registered winner; ties resolve to the lowest index.
module fast_argmax10
    import auction_pkg::*;
#(
    parameter int unsigned W = BID_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BIDDERS*W-1:0] bids,
    output logic [IDX_W-1:0]       win_idx,
    output logic [W-1:0]           win_bid
);

    typedef logic [IDX_W+W-1:0] cand_t;

    // Lower-index candidate always goes in lo, so ">" keeps ties on the lower index.
    function automatic cand_t pick(input cand_t lo, input cand_t hi);
        return (hi[W-1:0] > lo[W-1:0]) ? hi : lo;
    endfunction

    cand_t cand [NUM_BIDDERS];
    cand_t l1   [5];
    cand_t l2   [2];
    cand_t l3;
    cand_t best;

    always_comb begin
        for (int unsigned i = 0; i < NUM_BIDDERS; i++) begin
            cand[i] = {IDX_W'(i), bids[i*W +: W]};
        end
        for (int unsigned k = 0; k < 5; k++) begin
            l1[k] = pick(cand[2*k], cand[2*k+1]);
        end
        l2[0] = pick(l1[0], l1[1]);
        l2[1] = pick(l1[2], l1[3]);
        l3    = pick(l2[0], l2[1]);
        best  = pick(l3, l1[4]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_idx <= '0;
            win_bid <= '0;
        end else begin
            win_idx <= best[IDX_W+W-1:W];
            win_bid <= best[W-1:0];
        end
    end

endmodule

// File: rtl/auction_round_ctrl.sv
// Runs one bidding round at a time: open, collect bids, evaluate argmax, hold grant.
module auction_round_ctrl
    import auction_pkg::*;
#(
    parameter int unsigned bW      = 16,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_BIDDERS-1:0]    cfg_en,
    input  logic [NUM_BIDDERS-1:0]    bid_valid,
    input  logic [NUM_BIDDERS*bW-1:0] bid_value,
    output logic [NUM_BIDDERS-1:0]    bid_ready,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [bW-1:0]             grant_bid,
    input  logic                      grant_ready,
    output logic                      no_winner,
    output logic                      busy,
    output logic [CW-1:0]             round_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    state_t                   state;
    logic [NUM_BIDDERS-1:0]   en_q;
    logic [NUM_BIDDERS-1:0]   submitted;
    logic [NUM_BIDDERS-1:0]   hs;
    logic [NUM_BIDDERS-1:0]   sub_next;
    logic [TW-1:0]            timer;
    logic [bW-1:0]            bid_q [NUM_BIDDERS];
    logic [NUM_BIDDERS*bW-1:0] masked;
    logic                     any_bid;
    logic [IDX_W-1:0]         win_idx;
    logic [bW-1:0]            win_bid;

    always_comb begin
        bid_ready = (state == COLLECT) ? (en_q & ~submitted) : '0;
        hs        = bid_valid & bid_ready;
        sub_next  = submitted | hs;
        for (int unsigned i = 0; i < NUM_BIDDERS; i++) begin
            masked[i*bW +: bW] = submitted[i] ? bid_q[i] : '0;
        end
        any_bid = |masked;
    end

    fast_argmax10 #(
        .W (bW)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .bids    (masked),
        .win_idx (win_idx),
        .win_bid (win_bid)
    );

    // The argmax register is stable throughout GRANT because bid_q and the mask are frozen.
    assign busy      = (state != IDLE);
    assign grant_idx = grant_valid ? win_idx : '0;
    assign grant_bid = grant_valid ? win_bid : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            en_q        <= '0;
            submitted   <= '0;
            timer       <= '0;
            grant_valid <= 1'b0;
            no_winner   <= 1'b0;
            round_cnt   <= '0;
            for (int unsigned i = 0; i < NUM_BIDDERS; i++) begin
                bid_q[i] <= '0;
            end
        end else begin
            no_winner <= 1'b0;
            case (state)
                IDLE: begin
                    if (|(bid_valid & cfg_en)) begin
                        en_q      <= cfg_en;
                        submitted <= '0;
                        timer     <= '0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    for (int unsigned i = 0; i < NUM_BIDDERS; i++) begin
                        if (hs[i]) begin
                            bid_q[i] <= bid_value[i*bW +: bW];
                        end
                    end
                    submitted <= sub_next;
                    timer     <= timer + 1'b1;
                    if (sub_next == en_q || timer == TW'(TIMEOUT - 1)) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (!any_bid) begin
                        no_winner <= 1'b1;
                        submitted <= '0;
                        for (int unsigned i = 0; i < NUM_BIDDERS; i++) begin
                            bid_q[i] <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        round_cnt   <= round_cnt + 1'b1;
                        submitted   <= '0;
                        for (int unsigned i = 0; i < NUM_BIDDERS; i++) begin
                            bid_q[i] <= '0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_auction_round_ctrl.sv
// Scoreboard bench: each round's outcome is predicted at round open and checked by a monitor.
module tb_auction_round_ctrl;

    localparam int N  = 10;
    localparam int BW = 16;
    localparam int TO = 16;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    cfg_en = '0;
    logic [N-1:0]    bid_valid = '0;
    logic [N*BW-1:0] bid_value = '0;
    logic [N-1:0]    bid_ready;
    logic            grant_valid;
    logic [3:0]      grant_idx;
    logic [BW-1:0]   grant_bid;
    logic            grant_ready = 1'b0;
    logic            no_winner;
    logic            busy;
    logic [CW-1:0]   round_cnt;

    auction_round_ctrl #(.bW(BW), .TIMEOUT(TO), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en      (cfg_en),
        .bid_valid   (bid_valid),
        .bid_value   (bid_value),
        .bid_ready   (bid_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_bid   (grant_bid),
        .grant_ready (grant_ready),
        .no_winner   (no_winner),
        .busy        (busy),
        .round_cnt   (round_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            nw;
        logic [BW-1:0]   maxv;
        logic [N-1:0]    acc;
        logic [N*BW-1:0] vals;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [N-1:0]  cur_en = '0;
    logic [N-1:0]  done = '0;
    int            r_offs [N];
    logic [BW-1:0] r_vals [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each grant handshake or no_winner pulse.
    exp_t          m_e;
    logic          p_gv = 1'b0, p_gr = 1'b0, p_nw = 1'b0;
    logic [3:0]    p_idx = '0;
    logic [BW-1:0] p_bid = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_gv = 1'b0;
            p_nw = 1'b0;
        end else begin
            check("ready_mask", bid_ready & (~cur_en | done), '0);
            if (p_gv && !p_gr) begin
                check("hold_valid", grant_valid, 1);
                check("hold_idx", grant_idx, p_idx);
                check("hold_bid", grant_bid, p_bid);
            end
            if (p_gv && p_gr) check("grant_one_cycle", grant_valid, 0);
            if (p_nw) check("nowin_pulse", no_winner, 0);
            if (grant_valid) check("ready_in_grant", bid_ready, '0);
            if (grant_valid && grant_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got idx %0d bid %0h required none", grant_idx, grant_bid);
                end else begin
                    m_e = sb.pop_front();
                    check("grant_expected", m_e.nw, 0);
                    check("grant_bid_max", grant_bid, m_e.maxv);
                    check("grant_idx_submitted", m_e.acc[grant_idx], 1);
                    check("grant_idx_value", m_e.vals[grant_idx*BW +: BW], grant_bid);
                    check("round_cnt_at_grant", round_cnt, exp_cnt);
                    exp_cnt = exp_cnt + 1'b1;
                end
            end
            if (no_winner) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_no_winner: got 1 required 0");
                end else begin
                    m_e = sb.pop_front();
                    check("nowin_expected", m_e.nw, 1);
                    check("nowin_grant_low", grant_valid, 0);
                    check("nowin_round_cnt", round_cnt, exp_cnt);
                end
            end
            p_gv  = grant_valid;
            p_gr  = grant_ready;
            p_nw  = no_winner;
            p_idx = grant_idx;
            p_bid = grant_bid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bid_ready"}, bid_ready, '0);
        check({tag, "_grant_valid"}, grant_valid, 0);
        check({tag, "_grant_idx"}, grant_idx, 0);
        check({tag, "_grant_bid"}, grant_bid, 0);
        check({tag, "_no_winner"}, no_winner, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_round_cnt"}, round_cnt, 0);
    endtask

    // gmode: 0 random grant_ready, 1 held high, 2 held low 20 cycles, 3 reset while granting
    task automatic run_round(input logic [N-1:0] en, input int gmode, input bit flip);
        exp_t         e;
        bit           allin;
        int           maxo, clen, c, meas, guard;
        logic [N-1:0] hs;
        e = '0;
        allin = 1;
        maxo = 0;
        for (int i = 0; i < N; i++) begin
            e.vals[i*BW +: BW] = r_vals[i];
            if (en[i]) begin
                if (r_offs[i] >= 0 && r_offs[i] < TO) begin
                    e.acc[i] = 1'b1;
                    if (r_vals[i] > e.maxv) e.maxv = r_vals[i];
                    if (r_offs[i] > maxo) maxo = r_offs[i];
                end else begin
                    allin = 0;
                end
            end
        end
        clen = allin ? maxo + 1 : TO;
        e.nw = (e.maxv == 0);

        done = '0;
        cfg_en = en;
        bid_value = e.vals;
        for (int i = 0; i < N; i++) bid_valid[i] = (r_offs[i] == 0);
        @(posedge clk); #1;
        cur_en = en;
        sb.push_back(e);

        c = 0;
        meas = 0;
        while (c < TO + 4) begin
            for (int i = 0; i < N; i++)
                if (c > 0 && r_offs[i] == c && !done[i]) bid_valid[i] = 1'b1;
            if (flip) cfg_en = N'($urandom);
            @(negedge clk);
            if (bid_ready == '0) break;
            meas++;
            hs = bid_valid & bid_ready;
            @(posedge clk); #1;
            done = done | hs;
            bid_valid = bid_valid & ~hs;
            c++;
        end
        check("collect_cycles", meas, clen);
        check("eval_grant_low", grant_valid, 0);

        @(posedge clk); #1;
        bid_valid = '0;
        grant_ready = (gmode == 1) ? 1'b1 : (gmode == 0) ? 1'($urandom) : 1'b0;
        @(negedge clk);
        check("latency_grant", grant_valid, !e.nw);
        check("latency_nowin", no_winner, e.nw);

        if (gmode == 3 && !e.nw) begin
            repeat (3) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            sb.delete();
            exp_cnt = '0;
            cur_en = '0;
            done = '0;
            @(negedge clk);
            check_reset_outputs("mid_grant_reset");
            return;
        end

        guard = 0;
        while ((busy || grant_valid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            case (gmode)
                0: grant_ready = 1'($urandom);
                2: grant_ready = (guard >= 20);
                default: grant_ready = 1'b1;
            endcase
            @(negedge clk);
        end
        check("round_finished", busy || grant_valid, 0);
        check("round_cnt_after", round_cnt, exp_cnt);
        @(posedge clk); #1;
        grant_ready = 1'b0;
    endtask

    task automatic clear_round();
        for (int i = 0; i < N; i++) begin
            r_offs[i] = -1;
            r_vals[i] = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] en;
        int           op;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All ten bid in the first COLLECT cycle; requester 6 is the clear winner.
        clear_round();
        for (int i = 0; i < N; i++) begin
            r_offs[i] = 0;
            r_vals[i] = BW'(10 * i + 5);
        end
        r_vals[6] = 16'd200;
        run_round(10'h3FF, 1, 0);
        check("full_round_cnt", round_cnt, 1);

        // Only two of ten bid, so the round runs to timeout.
        clear_round();
        r_offs[2] = 0; r_vals[2] = 16'd40;
        r_offs[9] = 3; r_vals[9] = 16'd41;
        run_round(10'h3FF, 0, 0);

        // Single enabled requester bidding zero.
        clear_round();
        r_offs[3] = 0; r_vals[3] = 16'd0;
        run_round(10'h008, 0, 0);

        // Backpressure on the grant.
        clear_round();
        r_offs[1] = 0; r_vals[1] = 16'd77;
        r_offs[4] = 2; r_vals[4] = 16'd99;
        run_round(10'h012, 2, 0);

        // Masked requester 8 offers the largest value while cfg_en churns.
        clear_round();
        r_offs[0] = 0; r_vals[0] = 16'd300;
        r_offs[1] = 1; r_vals[1] = 16'd12;
        r_offs[2] = 4; r_vals[2] = 16'd301;
        r_offs[3] = 2; r_vals[3] = 16'd301;
        r_offs[8] = 0; r_vals[8] = 16'hFFFF;
        run_round(10'h00F, 0, 1);

        // Reset while a grant is held, then a normal round.
        clear_round();
        r_offs[5] = 0; r_vals[5] = 16'd1234;
        run_round(10'h020, 3, 0);
        clear_round();
        r_offs[7] = 0; r_vals[7] = 16'd9;
        r_offs[0] = 1; r_vals[0] = 16'd8;
        run_round(10'h081, 1, 0);

        for (int r = 0; r < 40; r++) begin
            en = N'($urandom_range(1, 1023));
            do op = $urandom_range(0, N - 1); while (!en[op]);
            for (int i = 0; i < N; i++) begin
                r_offs[i] = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TO + 2);
                case ($urandom_range(0, 3))
                    0: r_vals[i] = '0;
                    1: r_vals[i] = BW'($urandom_range(1, 6));
                    default: r_vals[i] = BW'($urandom);
                endcase
            end
            r_offs[op] = 0;
            run_round(en, $urandom_range(0, 2), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
